mem_sequencer: RTL and testbench

- Owns the single-port 8-bit byte-wide BRAM and shares it between two requesters: the instruction-fetch path (fixed 8-byte reads) and the load/store path (LDB/LDW/STB/STW, 1- or 4-byte accesses).
- Arbitrates round-robin and sequences multi-byte transfers as back-to-back byte accesses.
- Assembles and splits words big-endian: lowest address maps to the most significant byte.
- Sits between the CPU state machine and the bram instance.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/mem_sequencer_if.sv | 29 ++
 rtl/mem_rr_arb.sv | 23 ++
 rtl/mem_sequencer.sv | 87 ++++++++
 tb/tb_mem_sequencer.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the memory sequencer and its arbiter
package cpu_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;
    typedef enum logic {
        PORT_F = 1'b0,
        PORT_D = 1'b1
    } port_t;
    localparam logic SZ_BYTE = 1'b0;
    localparam logic SZ_WORD = 1'b1;
    localparam int FETCH_BYTES = 8;
endpackage

// File: rtl/mem_sequencer_if.sv
// mem_sequencer_if: fetch port, load/store port and BRAM pins of the sequencer
interface mem_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_done;
    logic [63:0]       f_rdata;
    logic              d_req;
    logic              d_we;
    logic              d_size;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_done;
    logic [31:0]       d_rdata;
    logic              busy;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [7:0]        bram_din;
    logic [7:0]        bram_dout;
    modport slave (
        input  f_req, f_addr, d_req, d_we, d_size, d_addr, d_wdata, bram_dout,
        output f_done, f_rdata, d_done, d_rdata, busy, bram_we, bram_addr, bram_din
    );
    modport master (
        output f_req, f_addr, d_req, d_we, d_size, d_addr, d_wdata, bram_dout,
        input  f_done, f_rdata, d_done, d_rdata, busy, bram_we, bram_addr, bram_din
    );
endinterface

// File: rtl/mem_rr_arb.sv
// mem_rr_arb: two-port round-robin arbiter; last_grant advances only when en is high
module mem_rr_arb
    import cpu_pkg::*;
(
    input  logic  Clk,
    input  logic  Rst_n,
    input  logic  en,
    input  logic  f_req,
    input  logic  d_req,
    output logic  gnt,
    output port_t gnt_port
);
    port_t last_grant;
    assign gnt = f_req | d_req;
    always_comb begin
        gnt_port = d_req ? PORT_D : PORT_F;
        if (f_req && d_req) gnt_port = (last_grant == PORT_F) ? PORT_D : PORT_F;
    end
    always_ff @(posedge Clk) begin
        if (!Rst_n) last_grant <= PORT_D;
        else if (en && gnt) last_grant <= gnt_port;
    end
endmodule

// File: rtl/mem_sequencer.sv
// mem_sequencer: shares a byte-wide BRAM between fetch and load/store ports,
// sequencing multi-byte transfers big-endian (lowest address = MSB)
module mem_sequencer
    import cpu_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int FETCH_BYTES = cpu_pkg::FETCH_BYTES
) (
    input logic            Clk,
    input logic            Rst_n,
    mem_sequencer_if.slave bus
);
    localparam int CW = $clog2(FETCH_BYTES) + 1;
    state_t            state, state_n;
    port_t             port_q, gnt_port;
    logic              gnt, we_q, size_q, last, capture;
    logic [ADDR_W-1:0] base_q;
    logic [CW-1:0]     cnt, n_q;
    logic [31:0]       wd_q;
    logic [63:0]       f_rdata_q;
    logic [31:0]       d_rdata_q;
    mem_rr_arb u_arb (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .en       (state == IDLE),
        .f_req    (bus.f_req),
        .d_req    (bus.d_req),
        .gnt      (gnt),
        .gnt_port (gnt_port)
    );
    assign last = cnt == n_q - CW'(1);
    // read data trails the address by one cycle, so capture starts on the second issue cycle
    assign capture = !we_q && ((state == ISSUE && cnt != '0) || state == WAIT);
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = gnt ? ISSUE : IDLE;
            ISSUE:   state_n = last ? (we_q ? DONE : WAIT) : ISSUE;
            WAIT:    state_n = DONE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge Clk) begin
        if (!Rst_n) state <= IDLE;
        else state <= state_n;
    end
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            port_q    <= PORT_D;
            base_q    <= '0;
            n_q       <= CW'(1);
            cnt       <= '0;
            we_q      <= 1'b0;
            size_q    <= SZ_BYTE;
            wd_q      <= '0;
            f_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (state == IDLE && gnt) begin
                port_q <= gnt_port;
                base_q <= (gnt_port == PORT_F) ? bus.f_addr : bus.d_addr;
                n_q    <= (gnt_port == PORT_F) ? CW'(FETCH_BYTES) :
                          (bus.d_size == SZ_WORD) ? CW'(4) : CW'(1);
                we_q   <= (gnt_port == PORT_D) && bus.d_we;
                size_q <= bus.d_size;
                // byte stores are left-aligned so the store path always emits wd_q[31:24]
                wd_q   <= (bus.d_size == SZ_WORD) ? bus.d_wdata : {bus.d_wdata[7:0], 24'h0};
                cnt    <= '0;
            end
            if (state == ISSUE) begin
                cnt  <= last ? cnt : cnt + CW'(1);
                wd_q <= {wd_q[23:0], 8'h0};
            end
            if (capture && port_q == PORT_F) f_rdata_q <= {f_rdata_q[55:0], bus.bram_dout};
            if (capture && port_q == PORT_D)
                d_rdata_q <= (size_q == SZ_WORD) ? {d_rdata_q[23:0], bus.bram_dout} : {24'h0, bus.bram_dout};
        end
    end
    assign bus.f_done    = state == DONE && port_q == PORT_F;
    assign bus.d_done    = state == DONE && port_q == PORT_D;
    assign bus.busy      = state != IDLE;
    assign bus.bram_we   = state == ISSUE && we_q;
    assign bus.bram_addr = base_q + ADDR_W'(cnt);
    assign bus.bram_din  = wd_q[31:24];
    assign bus.f_rdata   = f_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_mem_sequencer.sv
// tb_mem_sequencer: directed and random transactions checked against a byte-array memory model
module tb_mem_sequencer;
    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    always #5 Clk = ~Clk;

    mem_sequencer_if #(.ADDR_W(16)) bus ();
    mem_sequencer #(.ADDR_W(16)) dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bus));

    logic [7:0] mem     [0:65535];
    logic [7:0] ref_mem [0:65535];
    int checks = 0;
    int errors = 0;
    logic [63:0] last_f = '0;
    logic [31:0] last_d = '0;

    always @(posedge Clk) begin
        if (bus.bram_we) mem[bus.bram_addr] <= bus.bram_din;
        bus.bram_dout <= mem[bus.bram_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_fetch(input logic [15:0] a);
        logic [63:0] r = '0;
        for (int i = 0; i < 8; i++) r = {r[55:0], ref_mem[a + 16'(i)]};
        return r;
    endfunction

    function automatic logic [31:0] exp_load(input logic [15:0] a, input logic sz);
        logic [31:0] r = '0;
        if (!sz) return {24'h0, ref_mem[a]};
        for (int i = 0; i < 4; i++) r = {r[23:0], ref_mem[a + 16'(i)]};
        return r;
    endfunction

    task automatic start_tx(input logic is_f, input logic we, input logic sz, input logic [15:0] a, input logic [31:0] wd);
        if (is_f) begin
            bus.f_addr = a;
            bus.f_req  = 1'b1;
        end else begin
            bus.d_we    = we;
            bus.d_size  = sz;
            bus.d_addr  = a;
            bus.d_wdata = wd;
            bus.d_req   = 1'b1;
        end
    endtask

    task automatic run_tx(input logic is_f, input logic we, input logic sz, input logic [15:0] a, input logic [31:0] wd);
        int n = is_f ? 8 : (sz ? 4 : 1);
        int lat = (is_f || !we) ? n + 2 : n + 1;
        int got = 0;
        logic seq_ok = 1'b1;
        for (int k = 1; k <= 30 && got == 0; k++) begin
            @(posedge Clk); #1;
            if (k <= n && bus.bram_addr !== a + 16'(k - 1)) seq_ok = 1'b0;
            if (k <= n && bus.bram_we !== (!is_f && we)) seq_ok = 1'b0;
            if (is_f ? bus.d_done : bus.f_done) seq_ok = 1'b0;
            if (is_f ? bus.f_done : bus.d_done) got = k;
        end
        if (is_f) bus.f_req = 1'b0;
        else bus.d_req = 1'b0;
        chk(is_f ? "f_latency" : "d_latency", 64'(got), 64'(lat));
        chk("addr_we_seq", 64'(seq_ok), 64'(1));
        if (!is_f && we)
            for (int i = 0; i < n; i++) ref_mem[a + 16'(i)] = sz ? wd[31 - 8 * i -: 8] : wd[7:0];
        if (is_f) last_f = exp_fetch(a);
        else if (!we) last_d = exp_load(a, sz);
        chk("f_rdata", bus.f_rdata, last_f);
        chk("d_rdata", 64'(bus.d_rdata), 64'(last_d));
        @(posedge Clk); #1;
        chk("idle_after_done", 64'({bus.busy, bus.f_done, bus.d_done, bus.bram_we}), 64'(0));
    endtask

    task automatic tx(input logic is_f, input logic we, input logic sz, input logic [15:0] a, input logic [31:0] wd);
        start_tx(is_f, we, sz, a, wd);
        run_tx(is_f, we, sz, a, wd);
    endtask

    initial begin
        logic [7:0] v;
        int nf, nd, idle;
        logic [3:0] ord;
        logic rf, rd;
        logic is_f, we, sz;
        logic [15:0] a;
        for (int i = 0; i < 65536; i++) begin
            v = 8'($urandom);
            mem[i] <= v;
            ref_mem[i] = v;
        end
        for (int i = 0; i < 8; i++) begin
            mem[i] <= 8'(i + 1);
            ref_mem[i] = 8'(i + 1);
        end
        {bus.f_req, bus.d_req, bus.d_we, bus.d_size} = '0;
        bus.f_addr = '0;
        bus.d_addr = '0;
        bus.d_wdata = '0;
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_outputs", 64'({bus.busy, bus.bram_we, bus.f_done, bus.d_done}), 64'(0));
        chk("reset_f_rdata", bus.f_rdata, 64'(0));
        chk("reset_d_rdata", 64'(bus.d_rdata), 64'(0));

        // both requesters active out of reset: expect F, D, F, D
        bus.f_addr = 16'h0000;
        bus.d_we = 1'b0;
        bus.d_size = 1'b1;
        bus.d_addr = 16'h0100;
        bus.f_req = 1'b1;
        bus.d_req = 1'b1;
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        nf = 0; nd = 0; idle = 0; ord = '0; rf = 1'b0; rd = 1'b0;
        for (int c = 0; c < 100 && nf + nd < 4; c++) begin
            @(posedge Clk); #1;
            if (rf) begin bus.f_req = 1'b1; rf = 1'b0; end
            if (rd) begin bus.d_req = 1'b1; rd = 1'b0; end
            if (!bus.busy) idle++;
            if (bus.f_done) begin
                last_f = exp_fetch(16'h0000);
                chk("cont_f_rdata", bus.f_rdata, last_f);
                ord = {ord[2:0], 1'b0};
                nf++;
                bus.f_req = 1'b0;
                rf = nf < 2;
            end
            if (bus.d_done) begin
                last_d = exp_load(16'h0100, 1'b1);
                chk("cont_d_rdata", 64'(bus.d_rdata), 64'(last_d));
                ord = {ord[2:0], 1'b1};
                nd++;
                bus.d_req = 1'b0;
                rd = nd < 2;
            end
        end
        chk("rr_order", 64'(ord), 64'(4'b0101));
        chk("busy_gaps", 64'(idle), 64'(3));
        @(posedge Clk); #1;
        chk("cont_end_idle", 64'(bus.busy), 64'(0));

        tx(1'b1, 1'b0, 1'b0, 16'h0000, 32'h0);
        chk("fetch_const", bus.f_rdata, 64'h0102030405060708);
        tx(1'b0, 1'b1, 1'b1, 16'h0100, 32'hDEADBEEF);
        tx(1'b0, 1'b0, 1'b1, 16'h0100, 32'h0);
        chk("ldw_const", 64'(bus.d_rdata), 64'h00000000DEADBEEF);
        tx(1'b0, 1'b1, 1'b0, 16'h0020, 32'h123456A5);
        chk("stb_mem", 64'({mem[16'h001F], mem[16'h0020], mem[16'h0021]}),
            64'({ref_mem[16'h001F], 8'hA5, ref_mem[16'h0021]}));
        tx(1'b0, 1'b0, 1'b0, 16'h0020, 32'h0);
        chk("ldb_const", 64'(bus.d_rdata), 64'h00000000000000A5);
        tx(1'b0, 1'b0, 1'b1, 16'h001F, 32'h0);
        tx(1'b1, 1'b0, 1'b0, 16'hFFFC, 32'h0);

        // reset during cycle 4 of a fetch, request held across it
        start_tx(1'b1, 1'b0, 1'b0, 16'h1234, 32'h0);
        repeat (4) @(posedge Clk);
        #1;
        Rst_n = 1'b0;
        @(posedge Clk); #1;
        chk("midreset_state", 64'({bus.busy, bus.bram_we, bus.f_done, bus.d_done}), 64'(0));
        chk("midreset_f_rdata", bus.f_rdata, 64'(0));
        chk("midreset_d_rdata", 64'(bus.d_rdata), 64'(0));
        Rst_n = 1'b1;
        last_f = '0;
        last_d = '0;
        run_tx(1'b1, 1'b0, 1'b0, 16'h1234, 32'h0);

        for (int i = 0; i < 40; i++) begin
            is_f = ($urandom % 4) == 0;
            we = 1'($urandom);
            sz = 1'($urandom);
            a = ($urandom % 4 == 0) ? 16'(16'hFFFB + $urandom_range(0, 6)) : 16'($urandom);
            tx(is_f, we, sz, a, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
